fft_r22sdf_twiddle_gen: RTL and testbench

Twiddle-factor source for the R2²SDF FFT. It consumes the stage sample counter and produces the complex twiddle `W = exp(-j2πe/N)` that the twiddle multiplier at the same stage boundary needs. Each output is aligned with a delayed copy of the counter so the datapath can match it to the data sample. Values come from a quarter-wave cosine ROM expanded by quadrant symmetry in a 3-stage pipeline.

---
 rtl/fft_r22sdf_twiddle_gen.sv | 155 +++++++++++++++
 tb/tb_fft_r22sdf_twiddle_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_r22sdf_twiddle_gen.sv
// Twiddle-factor generator for one R2^2 SDF stage boundary.
// Maps the stage sample counter to W = exp(-j*2*pi*e/N) through a
// quarter-wave cosine ROM and quadrant symmetry, in a 3-stage pipeline.
// The counter and valid flag travel alongside so the datapath can pair
// each twiddle with its data sample.
module fft_r22sdf_twiddle_gen #(
  parameter int TWIDDLE_WIDTH = 10,
  parameter int FFT_N         = 1024,
  parameter int NLOG2         = 10
) (
  input  logic                            clk_i,
  input  logic                            rst_n,
  input  logic                            valid_i,
  input  logic [NLOG2-1:0]                ctr_i,
  output logic                            valid_o,
  output logic [NLOG2-1:0]                ctr_o,
  output logic signed [TWIDDLE_WIDTH-1:0] w_re_o,
  output logic signed [TWIDDLE_WIDTH-1:0] w_im_o
);

  // Quarter wave holds N/4+1 points so both r and N/4-r address it directly.
  localparam int QN   = FFT_N / 4;
  localparam int AW   = NLOG2 - 1;
  localparam int MW   = TWIDDLE_WIDTH - 1;
  localparam int MAXV = (2 ** MW) - 1;
  localparam real PI  = 3.14159265358979323846;
  localparam logic [AW-1:0] QN_ADDR = QN[AW-1:0];

  // Cosine table entry: rounded half away from zero (argument is in the
  // first quadrant, so value is non-negative) and clipped so that W=1
  // stays representable and negation can never overflow.
  function automatic logic [MW-1:0] cos_entry(input int idx);
    real ang;
    real val;
    int  iv;
    ang = 2.0 * PI * real'(idx) / real'(FFT_N);
    val = $cos(ang) * real'(2 ** MW);
    iv  = $rtoi(val + 0.5);
    if (iv > MAXV) iv = MAXV;
    if (iv < 0)    iv = 0;
    return iv[MW-1:0];
  endfunction

  logic [MW-1:0] rom [0:QN];

  // Constant ROM contents, one entry per table point.
  for (genvar gi = 0; gi <= QN; gi++) begin : g_rom
    assign rom[gi] = cos_entry(gi);
  end

  // ---------------- Stage 1: exponent e = bitrev2(m) * n ----------------
  logic [1:0]       m_sel;
  logic [NLOG2-1:0] n_ext;
  logic [NLOG2-1:0] e_next;

  assign m_sel = ctr_i[NLOG2-1 -: 2];
  assign n_ext = {2'b00, ctr_i[NLOG2-3:0]};

  // Multiply n by the bit-reversed quadrant index using shifts and adds.
  always_comb begin
    e_next = '0;
    case (m_sel)
      2'd0: e_next = '0;
      2'd1: e_next = n_ext << 1;             // m' = 2
      2'd2: e_next = n_ext;                  // m' = 1
      2'd3: e_next = (n_ext << 1) + n_ext;   // m' = 3
      default: e_next = '0;
    endcase
  end

  logic             valid_s1_reg;
  logic [NLOG2-1:0] ctr_s1_reg;
  logic [NLOG2-1:0] e_s1_reg;

  // Register the counter, its valid tag and the exponent.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      valid_s1_reg <= 1'b0;
      ctr_s1_reg   <= '0;
      e_s1_reg     <= '0;
    end else begin
      valid_s1_reg <= valid_i;
      ctr_s1_reg   <= ctr_i;
      e_s1_reg     <= e_next;
    end
  end

  // ---------------- Stage 2: quadrant split and ROM reads ----------------
  logic [AW-1:0] addr_r;
  logic [AW-1:0] addr_rb;

  assign addr_r  = {1'b0, e_s1_reg[NLOG2-3:0]};
  assign addr_rb = QN_ADDR - addr_r;

  logic             valid_s2_reg;
  logic [NLOG2-1:0] ctr_s2_reg;
  logic [1:0]       q_s2_reg;
  logic [MW-1:0]    c_r_s2_reg;
  logic [MW-1:0]    c_rb_s2_reg;

  // Registered dual-port ROM read of C(r) and C(N/4 - r), plus the quadrant.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      valid_s2_reg <= 1'b0;
      ctr_s2_reg   <= '0;
      q_s2_reg     <= '0;
      c_r_s2_reg   <= '0;
      c_rb_s2_reg  <= '0;
    end else begin
      valid_s2_reg <= valid_s1_reg;
      ctr_s2_reg   <= ctr_s1_reg;
      q_s2_reg     <= e_s1_reg[NLOG2-1 -: 2];
      c_r_s2_reg   <= rom[addr_r];
      c_rb_s2_reg  <= rom[addr_rb];
    end
  end

  // ---------------- Stage 3: quadrant sign mapping ----------------
  logic signed [TWIDDLE_WIDTH-1:0] pos_r;
  logic signed [TWIDDLE_WIDTH-1:0] pos_rb;
  logic signed [TWIDDLE_WIDTH-1:0] re_next;
  logic signed [TWIDDLE_WIDTH-1:0] im_next;

  assign pos_r  = {1'b0, c_r_s2_reg};
  assign pos_rb = {1'b0, c_rb_s2_reg};

  // Rotate the first-quadrant pair into the quadrant selected by q.
  always_comb begin
    re_next = '0;
    im_next = '0;
    case (q_s2_reg)
      2'd0: begin re_next =  pos_r;  im_next = -pos_rb; end
      2'd1: begin re_next = -pos_rb; im_next = -pos_r;  end
      2'd2: begin re_next = -pos_r;  im_next =  pos_rb; end
      2'd3: begin re_next =  pos_rb; im_next =  pos_r;  end
      default: begin re_next = '0; im_next = '0; end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      ctr_o   <= '0;
      w_re_o  <= '0;
      w_im_o  <= '0;
    end else begin
      valid_o <= valid_s2_reg;
      ctr_o   <= ctr_s2_reg;
      w_re_o  <= re_next;
      w_im_o  <= im_next;
    end
  end

endmodule

// File: tb/tb_fft_r22sdf_twiddle_gen.sv
// Scoreboard bench for fft_r22sdf_twiddle_gen at the default N=1024, TW=10.
// Stimulus pushes the expected twiddle for every valid input; a monitor
// pops and compares whenever valid_o is high.
module tb_fft_r22sdf_twiddle_gen;

  localparam int TW = 10;
  localparam int N  = 1024;
  localparam int NL = 10;
  localparam real PI = 3.14159265358979323846;

  logic                 clk_i = 1'b0;
  logic                 rst_n;
  logic                 valid_i;
  logic [NL-1:0]        ctr_i;
  logic                 valid_o;
  logic [NL-1:0]        ctr_o;
  logic signed [TW-1:0] w_re_o;
  logic signed [TW-1:0] w_im_o;

  fft_r22sdf_twiddle_gen #(
    .TWIDDLE_WIDTH(TW),
    .FFT_N        (N),
    .NLOG2        (NL)
  ) dut (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .valid_i(valid_i),
    .ctr_i  (ctr_i),
    .valid_o(valid_o),
    .ctr_o  (ctr_o),
    .w_re_o (w_re_o),
    .w_im_o (w_im_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int ctr;
    int re;
    int im;
    int tol;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Round half away from zero.
  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(0.5 - x);
  endfunction

  function automatic int clip(input int v);
    if (v > 511)  return 511;
    if (v < -511) return -511;
    return v;
  endfunction

  // Reference twiddle straight from trigonometry and a true multiply.
  task automatic model(input int c, output int re, output int im);
    int  m, n, mp, e;
    real a;
    m  = c / 256;
    n  = c % 256;
    mp = (m == 1) ? 2 : (m == 2) ? 1 : m;
    e  = mp * n;
    a  = 2.0 * PI * real'(e) / real'(N);
    re = clip(rnd(512.0 * $cos(a)));
    im = clip(rnd(-512.0 * $sin(a)));
  endtask

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("[TB] FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  // Present one input slot; queue its expected output when valid.
  task automatic drive(input bit v, input int c, input int re, input int im, input int tol);
    exp_t x;
    @(posedge clk_i);
    #1;
    valid_i = v;
    ctr_i   = c[NL-1:0];
    if (v) begin
      x.ctr = c; x.re = re; x.im = im; x.tol = tol;
      sb.push_back(x);
    end
  endtask

  task automatic drive_model(input int c);
    int re, im;
    model(c, re, im);
    drive(1'b1, c, re, im, 1);
  endtask

  // Started alongside the first post-reset drive: valid_o must stay low
  // for two edges and rise exactly on the third.
  task automatic check_latency();
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    check("latency_edge1_valid_o", int'(valid_o), 0);
    @(posedge clk_i);
    @(negedge clk_i);
    check("latency_edge2_valid_o", int'(valid_o), 0);
    @(posedge clk_i);
    @(negedge clk_i);
    check("latency_edge3_valid_o", int'(valid_o), 1);
  endtask

  // Monitor: compare every valid output against the scoreboard head.
  exp_t mon_x;
  int   mon_dre, mon_dim;
  bit   mon_ok;
  always @(negedge clk_i) begin
    if (rst_n && valid_o) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL stale_valid ctr_o=%0d got valid_o=1 required valid_o=0", ctr_o);
      end else begin
        mon_x   = sb.pop_front();
        mon_dre = int'(w_re_o) - mon_x.re;
        mon_dim = int'(w_im_o) - mon_x.im;
        if (mon_dre < 0) mon_dre = -mon_dre;
        if (mon_dim < 0) mon_dim = -mon_dim;
        mon_ok = (int'(ctr_o) == mon_x.ctr) && (mon_dre <= mon_x.tol) &&
                 (mon_dim <= mon_x.tol) && (int'(w_re_o) != -512) &&
                 (int'(w_im_o) != -512);
        if (mon_ok)
          $display("[TB] txn ctr=%0d re=%0d im=%0d ok", ctr_o, w_re_o, w_im_o);
        else begin
          n_fail++;
          $display("[TB] FAIL twiddle got ctr=%0d re=%0d im=%0d required ctr=%0d re=%0d im=%0d tol=%0d",
                   ctr_o, w_re_o, w_im_o, mon_x.ctr, mon_x.re, mon_x.im, mon_x.tol);
        end
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    ctr_i   = '0;

    // Reset state.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_valid_o", int'(valid_o), 0);
    check("reset_ctr_o",   int'(ctr_o),   0);
    check("reset_w_re_o",  int'(w_re_o),  0);
    check("reset_w_im_o",  int'(w_im_o),  0);

    @(posedge clk_i);
    #1;
    rst_n = 1'b1;

    // Quadrant m=0: every twiddle is 511 + 0j.
    fork check_latency(); join_none
    for (int c = 0; c < 256; c++) drive(1'b1, c, 511, 0, 0);

    // Directed angles and quadrant mapping.
    drive(1'b1, 257,  511,   -6, 0);
    drive(1'b1, 640,  362, -362, 0);
    drive(1'b1, 896, -362, -362, 0);
    drive(1'b1, 968, -439,  263, 0);
    drive(1'b1, 384,    0, -511, 0);

    // Valid gaps 1,0,0,1.
    drive(1'b1, 640,  362, -362, 0);
    drive(1'b0, 1,      0,    0, 0);
    drive(1'b0, 2,      0,    0, 0);
    drive(1'b1, 896, -362, -362, 0);

    // Full sweep against the trigonometric model.
    for (int c = 0; c < N; c++) drive_model(c);

    // Asynchronous reset in the middle of a stream.
    for (int c = 600; c <= 700; c++) drive_model(c);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid_o", int'(valid_o), 0);
    check("async_rst_ctr_o",   int'(ctr_o),   0);
    check("async_rst_w_re_o",  int'(w_re_o),  0);
    check("async_rst_w_im_o",  int'(w_im_o),  0);
    sb.delete();
    valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_n = 1'b1;

    // Restart: no stale valid, then 362/-362.
    fork check_latency(); join_none
    drive(1'b1, 640,  362, -362, 0);
    drive(1'b1, 896, -362, -362, 0);
    drive(1'b0, 0,      0,    0, 0);

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk_i);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain got %0d pending required 0", sb.size());
    end
    repeat (4) @(posedge clk_i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
